// File: rtl/key_ctrl.sv
// Front-panel key conditioner: 2-flop sync, debounce, press/release/long-press events.
// Optional KEY_CTRL_REPEAT_EN adds auto-repeat of key_press on the select key (bit 0).
module key_ctrl #(
    parameter int unsigned NKEY       = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DEB_CYC    = 20,
    parameter int unsigned LONG_CYC   = 200,
    parameter int unsigned REPEAT_CYC = 50
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NKEY-1:0] key_raw,
    output logic [NKEY-1:0] key_level,
    output logic [NKEY-1:0] key_press,
    output logic [NKEY-1:0] key_release,
    output logic [NKEY-1:0] key_long,
    output logic            key_any
);

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYC - 1);

    // Reject parameter sets that would make a counter wrap or never match.
    if (DEB_CYC < 1 || longint'(DEB_CYC) >= (longint'(1) << CNT_W) ||
        LONG_CYC < 1 || longint'(LONG_CYC) >= (longint'(1) << CNT_W) ||
        REPEAT_CYC < 1 || longint'(REPEAT_CYC) >= (longint'(1) << CNT_W)) begin : g_bad_param
        $error("key_ctrl: counter parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    logic [NKEY-1:0]  s1;
    logic [NKEY-1:0]  s2;
    logic [CNT_W-1:0] dcnt [NKEY];
    logic [CNT_W-1:0] hcnt [NKEY];
    state_t           state [NKEY];
    logic [NKEY-1:0]  accept_c;
    logic [NKEY-1:0]  rise_c;
    logic [NKEY-1:0]  fall_c;

`ifdef KEY_CTRL_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CYC - 1);
    logic [CNT_W-1:0] rcnt;
`endif

    // A level change is accepted on the edge where the debounce count expires.
    always_comb begin
        accept_c = '0;
        for (int i = 0; i < NKEY; i++) begin
            accept_c[i] = (s2[i] != key_level[i]) && (dcnt[i] == DEB_MAX);
        end
    end

    assign rise_c  = accept_c & s2;
    assign fall_c  = accept_c & ~s2;
    assign key_any = |key_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1          <= '0;
            s2          <= '0;
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            key_long    <= '0;
            for (int i = 0; i < NKEY; i++) begin
                dcnt[i]  <= '0;
                hcnt[i]  <= '0;
                state[i] <= ST_IDLE;
            end
`ifdef KEY_CTRL_REPEAT_EN
            rcnt <= '0;
`endif
        end else begin
            s1          <= key_raw;
            s2          <= s1;
            key_press   <= '0;
            key_release <= '0;
            key_long    <= '0;
            for (int i = 0; i < NKEY; i++) begin
                if (s2[i] == key_level[i] || accept_c[i]) begin
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + CNT_W'(1);
                end
                if (accept_c[i]) begin
                    key_level[i] <= s2[i];
                end

                case (state[i])
                    ST_IDLE: begin
                        if (rise_c[i]) begin
                            key_press[i] <= 1'b1;
                            hcnt[i]      <= '0;
                            state[i]     <= ST_PRESSED;
                        end
                    end
                    // A release landing on the long-press edge wins; hcnt saturates.
                    ST_PRESSED: begin
                        if (fall_c[i]) begin
                            key_release[i] <= 1'b1;
                            state[i]       <= ST_IDLE;
                        end else if (hcnt[i] == LONG_MAX) begin
                            key_long[i] <= 1'b1;
                            state[i]    <= ST_LONG;
                        end else begin
                            hcnt[i] <= hcnt[i] + CNT_W'(1);
                        end
                    end
                    ST_LONG: begin
                        if (fall_c[i]) begin
                            key_release[i] <= 1'b1;
                            state[i]       <= ST_IDLE;
                        end
                    end
                    default: state[i] <= ST_IDLE;
                endcase
            end

`ifdef KEY_CTRL_REPEAT_EN
            // Auto-repeat on select while long-held; cleared outside LONG and on release.
            if (state[0] == ST_LONG && !fall_c[0]) begin
                if (rcnt == REP_MAX) begin
                    key_press[0] <= 1'b1;
                    rcnt         <= '0;
                end else begin
                    rcnt <= rcnt + CNT_W'(1);
                end
            end else begin
                rcnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_key_ctrl.sv
// Scoreboard bench for key_ctrl: expected event cycles are queued when keys are driven.
module tb_key_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;
    localparam int LAT  = DEB + 2;

    logic       clk;
    logic       rst;
    logic [3:0] key_raw;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;
    logic       key_any;

    typedef struct {
        int         cyc;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lg;
    } ev_t;

    ev_t   exp_q[$];
    int    cyc = 0;
    int    vec_cnt = 0;
    int    err_cnt = 0;
    ev_t   mon_e;
    logic [11:0] mon_obs;
    logic [11:0] mon_exp;
    int    t;

    key_ctrl #(
        .NKEY      (4),
        .CNT_W     (16),
        .DEB_CYC   (DEB),
        .LONG_CYC  (LONG),
        .REPEAT_CYC(REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .key_any    (key_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_ev(input int c, input logic [3:0] pr, input logic [3:0] rl,
                           input logic [3:0] lg);
        ev_t e;
        e.cyc = c;
        e.pr  = pr;
        e.rl  = rl;
        e.lg  = lg;
        exp_q.push_back(e);
    endtask

    // Every cycle with an observed or expected event is compared against the queue head.
    always @(negedge clk) begin
        mon_obs = {key_press, key_release, key_long};
        mon_exp = '0;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e   = exp_q.pop_front();
            mon_exp = {mon_e.pr, mon_e.rl, mon_e.lg};
        end
        if (mon_obs != 12'h000 || mon_exp != 12'h000)
            check("events{press,rel,long}", 32'(mon_obs), 32'(mon_exp));
    end

    // Hold the keys in mask for n cycles, predicting press/long/repeat/release times.
    task automatic hold_keys(input logic [3:0] mask, input int n);
        int ts, pr, rl;
        ts = cyc;
        key_raw = key_raw | mask;
        pr = ts + LAT;
        rl = ts + n + LAT;
        push_ev(pr, mask, 4'h0, 4'h0);
        if (pr + LONG < rl) begin
            push_ev(pr + LONG, 4'h0, 4'h0, mask);
`ifdef KEY_CTRL_REPEAT_EN
            if (mask[0]) begin
                for (int p = pr + LONG + REP; p < rl; p += REP)
                    push_ev(p, 4'h1, 4'h0, 4'h0);
            end
`endif
        end
        push_ev(rl, 4'h0, mask, 4'h0);
        repeat (n) @(negedge clk);
        if (n > LAT) begin
            check("held_level", 32'(key_level), 32'(mask));
            check("held_any", 32'(key_any), 32'd1);
        end
        key_raw = key_raw & ~mask;
        repeat (LAT + 6) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        key_raw = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_level", 32'(key_level), 32'h0);
        check("rst_press", 32'(key_press), 32'h0);
        check("rst_release", 32'(key_release), 32'h0);
        check("rst_long", 32'(key_long), 32'h0);
        check("rst_any", 32'(key_any), 32'h0);

        // Keys held through reset release give a fresh press on all channels.
        t = cyc;
        rst = 1'b1;
        push_ev(t + LAT, 4'hF, 4'h0, 4'h0);
        repeat (10) @(negedge clk);
        check("post_rst_level", 32'(key_level), 32'hF);
        t = cyc;
        key_raw = 4'h0;
        push_ev(t + LAT, 4'h0, 4'hF, 4'h0);
        repeat (12) @(negedge clk);
        check("idle_any", 32'(key_any), 32'h0);

        // Bounce on start key: 3-cycle highs split by 1-cycle lows, then steady.
        for (int g = 0; g < 3; g++) begin
            key_raw[1] = 1'b1;
            repeat (3) @(negedge clk);
            key_raw[1] = 1'b0;
            @(negedge clk);
        end
        check("bounce_level", 32'(key_level), 32'h0);
        hold_keys(4'b0010, 10);

        hold_keys(4'b0100, 10);
        hold_keys(4'b1000, 40);
        hold_keys(4'b0101, 10);

        // Reset while the reset key sits in PRESSED: old hold must not reach key_long.
        t = cyc;
        key_raw[3] = 1'b1;
        push_ev(t + LAT, 4'h8, 4'h0, 4'h0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_level", 32'(key_level), 32'h0);
        check("midrst_any", 32'(key_any), 32'h0);
        t = cyc;
        rst = 1'b1;
        push_ev(t + LAT, 4'h8, 4'h0, 4'h0);
        repeat (10) @(negedge clk);
        check("midrst_relevel", 32'(key_level), 32'h8);
        t = cyc;
        key_raw = 4'h0;
        push_ev(t + LAT, 4'h0, 4'h8, 4'h0);
        repeat (12) @(negedge clk);

        // Long hold of select; repeat pulses expected only when the feature is built.
        hold_keys(4'b0001, 62);

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
